// File: rtl/counter_pkg.sv
// Shared types for the count direction decoder.
//   state_t : decoder FSM states (INIT / ACQ / UP / DOWN)
//   step_t  : classification of one accepted sample relative to the previous one
//   sat_inc8: saturating 8-bit increment used by the error counter
package counter_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ACQ  = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DOWN = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_JUMP = 2'd3
    } step_t;

    // Increment that sticks at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'd255) begin
            return 8'd255;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/step_classifier.sv
// Combinational classifier of one counter step.
// Ports:
//   prev       [WIDTH] previously accepted count value
//   count_in   [WIDTH] newly observed count value
//   step_class step_t  UP (+1), DOWN (-1), HOLD (0) or JUMP (anything else), mod 2^WIDTH
//   wrap       1       legal step crossing the all-ones <-> 0 boundary
module step_classifier
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_t            step_class,
    output logic             wrap
);

    logic [WIDTH-1:0] delta_s;
    logic [WIDTH-1:0] one_s;
    logic [WIDTH-1:0] ones_s;
    logic [WIDTH-1:0] zero_s;

    assign one_s  = {{(WIDTH-1){1'b0}}, 1'b1};
    assign ones_s = {WIDTH{1'b1}};
    assign zero_s = {WIDTH{1'b0}};

    // Modular subtraction: the natural wrap of WIDTH-bit arithmetic gives delta mod 2^WIDTH.
    assign delta_s = count_in - prev;

    // Decode delta into a step class and flag boundary crossings of legal steps.
    always_comb begin
        step_class = STEP_JUMP;
        wrap       = 1'b0;
        if (delta_s == one_s) begin
            step_class = STEP_UP;
            wrap       = (prev == ones_s);
        end else if (delta_s == ones_s) begin
            step_class = STEP_DOWN;
            wrap       = (prev == zero_s);
        end else if (delta_s == zero_s) begin
            step_class = STEP_HOLD;
            wrap       = 1'b0;
        end else begin
            step_class = STEP_JUMP;
            wrap       = 1'b0;
        end
    end

endmodule

// File: rtl/count_direction_decoder.sv
// Watches the output of an up/down counter and decides which way it is counting.
// A direction locks after CONFIRM consecutive same-direction steps; jumps are
// flagged and counted. All outputs are registered (one cycle after acceptance).
// Ports:
//   clk        clock, rising edge
//   clear_n    asynchronous active-low reset
//   valid      count_in is sampled this cycle
//   count_in   observed counter value [WIDTH]
//   dir_up     locked in the up direction
//   dir_down   locked in the down direction
//   locked     dir_up | dir_down
//   step_error one-cycle pulse on an illegal jump
//   wrap_event one-cycle pulse on a legal step across max <-> 0
//   err_count  saturating count of illegal jumps [8]
module count_direction_decoder
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CONFIRM = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir_up,
    output logic             dir_down,
    output logic             locked,
    output logic             step_error,
    output logic             wrap_event,
    output logic [7:0]       err_count
);

    localparam logic [3:0] CONF = CONFIRM[3:0];

    state_t           state_r;
    logic [WIDTH-1:0] prev_r;
    logic [3:0]       run_r;
    logic             cand_up_r;

    step_t            step_s;
    logic             wrap_s;
    logic [3:0]       run_inc_s;
    logic [3:0]       up_run_s;
    logic [3:0]       dn_run_s;
    logic             up_hit_s;
    logic             dn_hit_s;

    step_classifier #(.WIDTH(WIDTH)) u_classifier (
        .prev       (prev_r),
        .count_in   (count_in),
        .step_class (step_s),
        .wrap       (wrap_s)
    );

    // Run length that a step in each direction would produce: extend a matching
    // run, or restart at 1 when the candidate direction flips.
    assign run_inc_s = run_r + 4'd1;
    assign up_run_s  = cand_up_r  ? run_inc_s : 4'd1;
    assign dn_run_s  = !cand_up_r ? run_inc_s : 4'd1;
    assign up_hit_s  = (up_run_s == CONF);
    assign dn_hit_s  = (dn_run_s == CONF);

    // Direction FSM with registered outputs; only accepted samples change state.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r    <= ST_INIT;
            prev_r     <= '0;
            run_r      <= 4'd0;
            cand_up_r  <= 1'b1;
            dir_up     <= 1'b0;
            dir_down   <= 1'b0;
            locked     <= 1'b0;
            step_error <= 1'b0;
            wrap_event <= 1'b0;
            err_count  <= 8'd0;
        end else if (!valid) begin
            step_error <= 1'b0;
            wrap_event <= 1'b0;
        end else begin
            prev_r <= count_in;
            // The INIT sample has no predecessor, so it can raise no pulse.
            if (state_r == ST_INIT) begin
                step_error <= 1'b0;
                wrap_event <= 1'b0;
            end else begin
                wrap_event <= wrap_s;
                step_error <= (step_s == STEP_JUMP);
                if (step_s == STEP_JUMP) begin
                    err_count <= sat_inc8(err_count);
                end else begin
                    err_count <= err_count;
                end
            end
            case (state_r)
                ST_INIT: begin
                    state_r <= ST_ACQ;
                end
                ST_ACQ: begin
                    case (step_s)
                        STEP_UP: begin
                            cand_up_r <= 1'b1;
                            if (up_hit_s) begin
                                state_r  <= ST_UP;
                                dir_up   <= 1'b1;
                                dir_down <= 1'b0;
                                locked   <= 1'b1;
                                run_r    <= 4'd0;
                            end else begin
                                run_r <= up_run_s;
                            end
                        end
                        STEP_DOWN: begin
                            cand_up_r <= 1'b0;
                            if (dn_hit_s) begin
                                state_r  <= ST_DOWN;
                                dir_up   <= 1'b0;
                                dir_down <= 1'b1;
                                locked   <= 1'b1;
                                run_r    <= 4'd0;
                            end else begin
                                run_r <= dn_run_s;
                            end
                        end
                        STEP_JUMP: run_r <= 4'd0;
                        default:   run_r <= run_r;
                    endcase
                end
                ST_UP: begin
                    case (step_s)
                        // Reversal starts a fresh down run of 1; with CONFIRM=1
                        // that run already confirms the new direction.
                        STEP_DOWN: begin
                            cand_up_r <= 1'b0;
                            dir_up    <= 1'b0;
                            if (CONF == 4'd1) begin
                                state_r  <= ST_DOWN;
                                dir_down <= 1'b1;
                                locked   <= 1'b1;
                                run_r    <= 4'd0;
                            end else begin
                                state_r  <= ST_ACQ;
                                dir_down <= 1'b0;
                                locked   <= 1'b0;
                                run_r    <= 4'd1;
                            end
                        end
                        STEP_JUMP: begin
                            state_r <= ST_ACQ;
                            dir_up  <= 1'b0;
                            locked  <= 1'b0;
                            run_r   <= 4'd0;
                        end
                        default: state_r <= ST_UP;
                    endcase
                end
                ST_DOWN: begin
                    case (step_s)
                        STEP_UP: begin
                            cand_up_r <= 1'b1;
                            dir_down  <= 1'b0;
                            if (CONF == 4'd1) begin
                                state_r <= ST_UP;
                                dir_up  <= 1'b1;
                                locked  <= 1'b1;
                                run_r   <= 4'd0;
                            end else begin
                                state_r <= ST_ACQ;
                                dir_up  <= 1'b0;
                                locked  <= 1'b0;
                                run_r   <= 4'd1;
                            end
                        end
                        STEP_JUMP: begin
                            state_r  <= ST_ACQ;
                            dir_down <= 1'b0;
                            locked   <= 1'b0;
                            run_r    <= 4'd0;
                        end
                        default: state_r <= ST_DOWN;
                    endcase
                end
                default: begin
                    state_r  <= ST_INIT;
                    dir_up   <= 1'b0;
                    dir_down <= 1'b0;
                    locked   <= 1'b0;
                    run_r    <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_direction_decoder.sv
// Scoreboard bench: the driver pushes the reference model's expected response for
// every accepted sample; a monitor pops and compares one cycle after acceptance.
module tb_count_direction_decoder;

    localparam int W    = 4;
    localparam int CONF = 2;
    localparam int MOD  = 1 << W;

    logic         clk;
    logic         clear_n;
    logic         valid;
    logic [W-1:0] count_in;
    logic         dir_up;
    logic         dir_down;
    logic         locked;
    logic         step_error;
    logic         wrap_event;
    logic [7:0]   err_count;

    typedef struct {
        logic       up;
        logic       down;
        logic       serr;
        logic       wrap;
        logic [7:0] errs;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: direction as +1/-1/0, candidate as +1/-1.
    int m_have, m_prev, m_run, m_cand, m_dir, m_errs;

    count_direction_decoder #(.WIDTH(W), .CONFIRM(CONF)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .valid      (valid),
        .count_in   (count_in),
        .dir_up     (dir_up),
        .dir_down   (dir_down),
        .locked     (locked),
        .step_error (step_error),
        .wrap_event (wrap_event),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_run = 0; m_cand = 1; m_dir = 0; m_errs = 0;
    endtask

    task automatic model_step(input int c, output exp_t e);
        int d;
        int s;
        bit wr;
        wr = 1'b0;
        if (m_have == 0) begin
            m_have = 1;
            e.serr = 1'b0;
        end else begin
            d = ((c - m_prev) % MOD + MOD) % MOD;
            s = (d == 1) ? 1 : (d == MOD - 1) ? -1 : (d == 0) ? 0 : 2;
            wr = (s == 1 && m_prev == MOD - 1) || (s == -1 && m_prev == 0);
            e.serr = (s == 2);
            if (s == 2) begin
                if (m_errs < 255) m_errs++;
                m_run = 0;
                m_dir = 0;
            end else if (s != 0 && m_dir != s) begin
                if (m_dir == -s || m_cand != s) begin
                    m_cand = s;
                    m_run  = 1;
                end else begin
                    m_run++;
                end
                m_dir = 0;
                if (m_run == CONF) m_dir = s;
            end
        end
        m_prev = c;
        e.wrap = wr;
        e.up   = (m_dir == 1);
        e.down = (m_dir == -1);
        e.errs = 8'(m_errs);
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic send(input int c);
        exp_t e;
        @(negedge clk);
        valid    = 1'b1;
        count_in = W'(c);
        model_step(c, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    // Asynchronous reset checked immediately, then released with valid low.
    task automatic do_reset();
        @(negedge clk);
        valid   = 1'b0;
        clear_n = 1'b0;
        #1;
        check("reset_dir_up", dir_up, 0);
        check("reset_dir_down", dir_down, 0);
        check("reset_locked", locked, 0);
        check("reset_pulses", {step_error, wrap_event}, 0);
        check("reset_err_count", err_count, 0);
        model_reset();
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    // Monitor: an accepted sample yields a response one cycle later; idle cycles must be pulse-free.
    always @(posedge clk) begin
        bit acc;
        exp_t e;
        acc = (valid === 1'b1) && (clear_n === 1'b1);
        #1;
        if (clear_n === 1'b1) begin
            if (acc) begin
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dir_up", dir_up, e.up);
                    check("dir_down", dir_down, e.down);
                    check("locked", locked, e.up | e.down);
                    check("step_error", step_error, e.serr);
                    check("wrap_event", wrap_event, e.wrap);
                    check("err_count", err_count, e.errs);
                end
            end else begin
                check("idle_pulses", {step_error, wrap_event}, 0);
            end
        end
    end

    initial begin
        int v;
        int r;
        clear_n  = 1'b0;
        valid    = 1'b0;
        count_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        clear_n = 1'b1;

        // Up lock: 3,4,5 -> dir_up after 5.
        send(3); send(4); send(5);
        // Jump from locked UP at 5 to 9, then relock with 10,11.
        send(9); send(10); send(11);
        do_reset();
        // Down lock and wrap: 1,0,15,14.
        send(1); send(0); send(15); send(14);
        do_reset();
        // Reversal with holds: lock UP at 7, then 7,7,6,5.
        send(5); send(6); send(7); send(7); send(7); send(6); send(5);
        do_reset();
        // Valid gap: 2 and 3 separated by 5 idle cycles.
        send(2); idle(5); send(3); idle(3); send(4);
        do_reset();
        // Up wrap 14,15,0,1.
        send(14); send(15); send(0); send(1);
        do_reset();
        // Saturation: 300 jumps, then reset mid-stream and a capture-only sample.
        for (int i = 0; i <= 300; i++) send((i % 2) * 8);
        idle(1);
        check("saturated_err_count", err_count, 255);
        do_reset();
        send(6); send(7); send(8);
        do_reset();

        // Random walk with occasional jumps, holds and idle gaps.
        v = 0;
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10)      v = int'($urandom_range(0, MOD - 1));
            else if (r < 20) v = v;
            else if (r < 60) v = (v + 1) % MOD;
            else             v = (v + MOD - 1) % MOD;
            send(v);
            if ($urandom_range(0, 9) < 2) idle(int'($urandom_range(1, 3)));
            if (i == 250) do_reset();
        end
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
